// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: start/done handshake, operands and results of the bit-serial subtractor.
interface serial_subtractor_if #(parameter int WIDTH = 4);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;
  modport master (output start, a, b, bin, input busy, done, diff, bout, ovf);
  modport slave  (input start, a, b, bin, output busy, done, diff, bout, ovf);
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor: LSB-first bit-serial a - b - bin over WIDTH cycles using one full-subtractor cell.
// Define SERIAL_SUB_SIGNED_OVF_EN to build the two's-complement overflow flag (ovf is tied to 0 otherwise).
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input logic               clk,
  input logic               rst_n,
  serial_subtractor_if.slave bus
);
  typedef enum logic {IDLE, RUN} state_t;
  localparam int CW = $clog2(WIDTH);
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_res, r_diff, w_res;
  logic [CW-1:0]    r_cnt;
  logic             r_brw, r_bout, r_done;
  logic             w_run, w_accept, w_last, w_d, w_brw;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  always_comb
    w_next = (r_state == IDLE) ? (bus.start ? RUN : IDLE) : (w_last ? IDLE : RUN);
  always_comb begin
    w_run    = (r_state == RUN);
    w_accept = (r_state == IDLE) && bus.start;
    w_last   = w_run && (r_cnt == CW'(WIDTH - 1));
    w_d      = r_a[0] ^ r_b[0] ^ r_brw;
    w_brw    = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_brw);
    w_res    = {w_d, r_res[WIDTH-1:1]};
  end
  // Result bits enter at the MSB so after WIDTH shifts bit 0 lands at the LSB.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_res  <= '0;
      r_brw  <= 1'b0;
      r_cnt  <= '0;
      r_diff <= '0;
      r_bout <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_accept) begin
        r_a   <= bus.a;
        r_b   <= bus.b;
        r_brw <= bus.bin;
        r_cnt <= '0;
      end else if (w_run) begin
        r_a   <= r_a >> 1;
        r_b   <= r_b >> 1;
        r_res <= w_res;
        r_brw <= w_brw;
        r_cnt <= r_cnt + CW'(1);
        if (w_last) begin
          r_diff <= w_res;
          r_bout <= w_brw;
        end
      end
    end
  assign bus.busy = w_run;
  assign bus.done = r_done;
  assign bus.diff = r_diff;
  assign bus.bout = r_bout;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  logic r_amsb, r_bmsb, r_ovf;
  // Operand MSBs are kept aside because the shift registers are drained by completion.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_amsb <= 1'b0;
      r_bmsb <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (w_accept) begin
      r_amsb <= bus.a[WIDTH-1];
      r_bmsb <= bus.b[WIDTH-1];
    end else if (w_last)
      r_ovf <= (r_amsb ^ r_bmsb) & (r_amsb ^ w_res[WIDTH-1]);
  assign bus.ovf = r_ovf;
`else
  assign bus.ovf = 1'b0;
`endif
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: vector table, hand-written handshake corners and random operands vs an arithmetic model.
module tb_serial_subtractor;
  localparam int W = 4;
  typedef struct {
    int a;
    int b;
    int bin;
    int diff;
    int bout;
    int ovf;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  serial_subtractor_if #(.WIDTH(W)) bus();
  serial_subtractor #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic int ovf_exp(input int v);
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    return v;
`else
    return 0;
`endif
  endfunction
  task automatic model(input int a, input int b, input int bin,
                       output int d, output int bo, output int ov);
    int half, sa, sb, r;
    half = 1 << (W - 1);
    d    = (a - b - bin) & ((1 << W) - 1);
    bo   = (a < b + bin) ? 1 : 0;
    sa   = (a >= half) ? a - (1 << W) : a;
    sb   = (b >= half) ? b - (1 << W) : b;
    r    = sa - sb - bin;
    ov   = ovf_exp((r < -half || r >= half) ? 1 : 0);
  endtask
  task automatic run_op(input int a, input int b, input int bin,
                        input int ed, input int eb, input int eo, input string tag);
    int k;
    k = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = W'(a);
    bus.b     = W'(b);
    bus.bin   = bin[0];
    @(posedge clk) #1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.bin   = 1'b0;
    chk({tag, " busy_after_start"}, 32'(bus.busy), 1);
    for (int i = 1; i <= W + 2; i++) begin
      @(posedge clk) #1;
      if (bus.done) begin
        k = i;
        break;
      end
      if (!bus.busy) break;
    end
    chk({tag, " latency"}, k, W);
    chk({tag, " diff"}, 32'(bus.diff), ed);
    chk({tag, " bout"}, 32'(bus.bout), eb);
    chk({tag, " ovf"}, 32'(bus.ovf), eo);
    chk({tag, " busy_at_done"}, 32'(bus.busy), 0);
    @(posedge clk) #1;
    chk({tag, " done_one_cycle"}, 32'(bus.done), 0);
  endtask
  vec_t vt[8];
  initial begin
    int d, bo, ov, bad;
    vt[0] = '{5, 3, 0, 2, 0, 0};
    vt[1] = '{3, 5, 0, 14, 1, 0};
    vt[2] = '{0, 0, 1, 15, 1, 0};
    vt[3] = '{8, 1, 0, 7, 0, 1};
    vt[4] = '{6, 1, 0, 5, 0, 0};
    vt[5] = '{15, 15, 1, 15, 1, 0};
    vt[6] = '{0, 15, 0, 1, 1, 0};
    vt[7] = '{7, 8, 0, 15, 1, 1};
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.bin   = 1'b0;
    #12;
    chk("reset_outputs", 32'({bus.busy, bus.done, bus.diff, bus.bout, bus.ovf}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    foreach (vt[i])
      run_op(vt[i].a, vt[i].b, vt[i].bin, vt[i].diff, vt[i].bout, ovf_exp(vt[i].ovf), $sformatf("vec%0d", i));
    // start re-asserted during RUN must be ignored
    @(negedge clk);
    bus.start = 1'b1; bus.a = 4'd9; bus.b = 4'd2; bus.bin = 1'b0;
    @(posedge clk) #1;
    bus.start = 1'b0;
    @(posedge clk) #1;
    bus.start = 1'b1; bus.a = 4'd1; bus.b = 4'd1;
    @(posedge clk) #1;
    bus.start = 1'b0;
    chk("ign busy", 32'(bus.busy), 1);
    @(posedge clk);
    @(posedge clk) #1;
    chk("ign done", 32'(bus.done), 1);
    chk("ign diff", 32'(bus.diff), 7);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk) #1;
      if (bus.done || bus.busy) bad++;
    end
    chk("ign no_extra_op", bad, 0);
    // start held high: back-to-back operations
    @(negedge clk);
    bus.start = 1'b1; bus.a = 4'd4; bus.b = 4'd1; bus.bin = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk) #1;
      if (i == 4 || i == 9) begin
        chk($sformatf("held done@%0d", i), 32'(bus.done), 1);
        chk($sformatf("held diff@%0d", i), 32'(bus.diff), 3);
      end
      if (i == 5) chk("held done_low@5", 32'(bus.done), 0);
      if (i == 5) chk("held busy@5", 32'(bus.busy), 1);
    end
    bus.start = 1'b0;
    repeat (6) @(posedge clk);
    // asynchronous reset in the third RUN cycle
    @(negedge clk);
    bus.start = 1'b1; bus.a = 4'd5; bus.b = 4'd3;
    @(posedge clk) #1;
    bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk) #1;
    chk("rst diff_before", 32'(bus.diff), 3);
    rst_n = 1'b0;
    #1;
    chk("rst outputs_clear", 32'({bus.busy, bus.done, bus.diff, bus.bout, bus.ovf}), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk) #1;
      if (bus.done || bus.busy) bad++;
    end
    chk("rst no_done", bad, 0);
    run_op(6, 6, 0, 0, 0, 0, "post_rst");
    for (int i = 0; i < 40; i++) begin
      int ra, rb, rc;
      ra = int'($urandom_range(0, (1 << W) - 1));
      rb = int'($urandom_range(0, (1 << W) - 1));
      rc = int'($urandom_range(0, 1));
      model(ra, rb, rc, d, bo, ov);
      run_op(ra, rb, rc, d, bo, ov, $sformatf("rnd%0d a=%0d b=%0d bin=%0d", i, ra, rb, rc));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
